m_hart_mem_arbiter: RTL and testbench
=====================================

// Module: m_hart_mem_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single memory/MMU port of an RV cluster between N_HARTS cores.
//  Grants one hart at a time and switches only at instruction-commit boundaries, never mid-transaction.
//  Inserts a one-cycle turnaround on every hand-over and enforces a fairness quantum.
//  Sits between the per-hart core/MMU instances and the cluster-level mux driving the memory controller.
// PARAMETERS
//  N_HARTS  1  number of requesting harts (>=1)
//  QUANTUM  4  commit boundaries a hart may hold the port while another hart is requesting (>=1)
//  SELW     $clog2(N_HARTS+1)  width of o_sel (derived; not overridden)
// PORTS
//  CLK          in   1        clock
//  RST_X        in   1        reset, asynchronous, active-low
//  i_req        in   N_HARTS  hart g wants the memory port (level)
//  i_done       in   N_HARTS  hart g is at a commit boundary this cycle (pipeline idle and insn taken)
//  i_lock       in   N_HARTS  hart g forbids hand-over (CSR op / PTE walk / atomic in flight)
//  i_mem_busy   in   1        shared memory-controller busy
//  o_valid      out  1        a hart owns the port (state GRANT)
//  o_sel        out  SELW     index of the owning or most-recent hart (cluster mux select)
//  o_grant      out  N_HARTS  one-hot owner; all zero when o_valid=0
//  o_core_busy  out  N_HARTS  per-hart busy: owner sees i_mem_busy, every other hart sees 1
// BEHAVIOUR
//  Reset (async, RST_X=0): state=IDLE, o_valid=0, o_grant=0, o_sel=0, rr pointer=N_HARTS-1
//   (first grant goes to hart 0), quantum counter=0, o_core_busy=all 1. Takes effect immediately,
//   including mid-GRANT; outputs are clean on the first edge after RST_X rises.
//  FSM, registered, one transition per CLK:
//   IDLE : no requests -> IDLE. Any i_req -> GRANT to the first requester at or after
//          ptr+1 (mod N_HARTS, wrapping). ptr:=winner, count:=0.
//   GRANT: owner s=o_sel. "yield" = i_done[s] & !i_lock[s] & !i_mem_busy.
//          yield & !i_req[s]                      -> TURN.
//          yield & other req & (count+1==QUANTUM) -> TURN.
//          yield, otherwise                       -> stay in GRANT; count += 1 only if another hart requests,
//                                                    else count := 0.
//          no yield                               -> stay in GRANT; count unchanged.
//          i_lock[s]=1 or i_mem_busy=1 always blocks hand-over regardless of count.
//   TURN : exactly 1 cycle; o_valid=0, o_grant=0, o_core_busy=all 1, o_sel holds the old value.
//          Any i_req -> GRANT, searching from o_sel+1 (wrap), so the previous owner has lowest
//          priority; the previous owner wins only if it is the sole requester. Else -> IDLE.
//  Latency: request to grant is 1 cycle from IDLE and 1 cycle after TURN. Hand-over costs 1 dead cycle.
//  o_core_busy[g] = (o_valid && o_sel==g) ? i_mem_busy : 1'b1. Combinational from i_mem_busy only.
//  o_grant and o_valid are registered. o_sel changes only on entry to GRANT.
//  N_HARTS=1: behaves identically with wrap to 0; continuous i_req[0] never leaves GRANT
//   (no competitor, so count stays 0).
//  i_req dropped mid-GRANT without i_done: the owner keeps the port until a yield (no mid-op abort).
//  count is SELW-independent, $clog2(QUANTUM+1) bits, and never exceeds QUANTUM-1.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds output o_grant_cnt [32*N_HARTS-1:0].
//   Slice g is a wrapping 32-bit count of GRANT entries for hart g. It increments on the cycle the
//   state enters GRANT with winner g, and resets to 0 on RST_X.
//  Undefined: port and counters absent; the remaining behaviour is identical.
// TESTING
//  T1 reset mid-GRANT: drop RST_X between edges -> o_valid=0, o_grant=0, o_core_busy=all 1
//     immediately; release with i_req=0b0100 -> o_grant=0b0100 one cycle later.
//  T2 N=4, i_req=0b1111, i_done pulses every cycle, no lock, QUANTUM=4 -> owners 0,1,2,3,0.
//     Each owner sees 4 done pulses, then 1 TURN cycle with o_valid=0.
//  T3 owner 1, i_lock[1]=1 across 10 done pulses with i_req=0b0011 -> o_sel stays 1 throughout.
//     Drop the lock -> hand-over to 0 only after count reaches QUANTUM.
//  T4 owner 2, i_mem_busy=1 -> o_core_busy=0b1111; i_mem_busy=0 -> 0b1011, no switch while busy.
//  T5 only hart 3 requesting, i_done=1 for 20 cycles -> stays GRANT, no TURN cycles.
//     Drop i_req[3] at a done -> TURN, then IDLE.
//  T6 with ARB_PERF_CNT_EN: run T2 for 2 rounds -> o_grant_cnt slices = {2,2,2,2}; after reset all 0.

Source files
------------

// File: rtl/m_hart_mem_arbiter.sv
// m_hart_mem_arbiter
//   Round-robin owner of the shared memory/MMU port of an RV cluster. A hart keeps
//   the port until it yields at a commit boundary (done, not locked, memory idle);
//   every hand-over costs one dead TURN cycle, and a contested owner is forced out
//   after QUANTUM commit boundaries.
// Ports
//   CLK, RST_X   clock, asynchronous active-low reset
//   i_req        per-hart port request (level)
//   i_done       per-hart commit boundary this cycle
//   i_lock       per-hart hand-over inhibit (CSR op / PTE walk / atomic)
//   i_mem_busy   shared memory-controller busy
//   o_valid      a hart owns the port
//   o_sel        index of the owning or most recent hart
//   o_grant      one-hot owner, zero when o_valid=0
//   o_core_busy  per-hart busy: owner sees i_mem_busy, others see 1
//   o_grant_cnt  (ARB_PERF_CNT_EN only) 32-bit GRANT-entry count per hart
// Configuration macro: ARB_PERF_CNT_EN
module m_hart_mem_arbiter #(
   parameter  int unsigned N_HARTS = 1,
   parameter  int unsigned QUANTUM = 4,
   localparam int unsigned SELW    = $clog2(N_HARTS + 1)
) (
   input  logic               CLK,
   input  logic               RST_X,
   input  logic [N_HARTS-1:0] i_req,
   input  logic [N_HARTS-1:0] i_done,
   input  logic [N_HARTS-1:0] i_lock,
   input  logic               i_mem_busy,
   output logic               o_valid,
   output logic [SELW-1:0]    o_sel,
   output logic [N_HARTS-1:0] o_grant,
   output logic [N_HARTS-1:0] o_core_busy
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [32*N_HARTS-1:0] o_grant_cnt
`endif
);

   localparam int unsigned CW = $clog2(QUANTUM + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_TURN  = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [SELW-1:0]    r_sel;
   logic [SELW-1:0]    w_sel_nxt;
   logic [SELW-1:0]    r_ptr;
   logic [SELW-1:0]    w_ptr_nxt;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      w_cnt_nxt;
   logic               r_valid;
   logic [N_HARTS-1:0] r_grant;
   logic [N_HARTS-1:0] w_grant_nxt;
   logic [N_HARTS-1:0] w_own;
   logic               w_req_own;
   logic               w_others;
   logic               w_yield;
   logic [SELW-1:0]    w_base;
   logic [SELW-1:0]    w_pick;

   // One-hot decode of the current owner index
   always_comb begin
      w_own = '0;
      for (int g = 0; g < int'(N_HARTS); g++) begin
         w_own[g] = (r_sel == SELW'(g));
      end
   end

   assign w_req_own = |(i_req & w_own);
   assign w_others  = |(i_req & ~w_own);
   assign w_yield   = (|(i_done & w_own & ~i_lock)) & ~i_mem_busy;

   // After TURN the search starts past the old owner, otherwise past the rr pointer
   assign w_base = (r_state == S_TURN) ? r_sel : r_ptr;

   // Round-robin pick: requester with the smallest forward distance from w_base+1
   always_comb begin
      int best;
      int d;
      best   = int'(N_HARTS);
      d      = 0;
      w_pick = w_base;
      for (int g = 0; g < int'(N_HARTS); g++) begin
         if (i_req[g]) begin
            d = g + int'(N_HARTS) - int'(w_base) - 1;
            if (d >= int'(N_HARTS)) d = d - int'(N_HARTS);
            if (d < best) begin
               best   = d;
               w_pick = SELW'(g);
            end
         end
      end
   end

   // Next-state and next-owner logic
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE, S_TURN: begin
            if (|i_req) begin
               w_state_nxt = S_GRANT;
               w_sel_nxt   = w_pick;
               w_ptr_nxt   = w_pick;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_GRANT: begin
            if (w_yield) begin
               if (!w_req_own || (w_others && ((r_cnt + CW'(1)) == CW'(QUANTUM)))) begin
                  w_state_nxt = S_TURN;
                  w_cnt_nxt   = '0;
               end else if (w_others) begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end else begin
                  w_cnt_nxt = '0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_grant_nxt = '0;
      for (int g = 0; g < int'(N_HARTS); g++) begin
         w_grant_nxt[g] = (w_state_nxt == S_GRANT) && (w_sel_nxt == SELW'(g));
      end
   end

   // State and registered outputs
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_state <= S_IDLE;
         r_sel   <= '0;
         r_ptr   <= SELW'(N_HARTS - 1);
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_grant <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= (w_state_nxt == S_GRANT);
         r_grant <= w_grant_nxt;
      end
   end

   assign o_valid = r_valid;
   assign o_sel   = r_sel;
   assign o_grant = r_grant;

   // Only the owner sees the live memory busy; everyone else is stalled
   always_comb begin
      o_core_busy = '1;
      for (int g = 0; g < int'(N_HARTS); g++) begin
         if (r_valid && r_grant[g]) o_core_busy[g] = i_mem_busy;
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [N_HARTS-1:0][31:0] r_gcnt;
   logic                     w_enter;

   assign w_enter = (r_state != S_GRANT) && (w_state_nxt == S_GRANT);

   // GRANT-entry counters, wrapping
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_gcnt <= '0;
      end else if (w_enter) begin
         for (int g = 0; g < int'(N_HARTS); g++) begin
            if (w_sel_nxt == SELW'(g)) r_gcnt[g] <= r_gcnt[g] + 32'd1;
         end
      end
   end

   assign o_grant_cnt = r_gcnt;
`else
   // No performance counters in this build
`endif

endmodule

// File: tb/tb_m_hart_mem_arbiter.sv
// Bench for m_hart_mem_arbiter (N_HARTS=4, QUANTUM=4): directed scenarios with
// literal expectations, then randomized traffic compared every cycle against an
// owner/turnaround model of the arbitration rules.
module tb_m_hart_mem_arbiter;

   localparam int N = 4;
   localparam int Q = 4;

   logic       CLK;
   logic       RST_X;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] lock;
   logic       busy;
   logic       o_valid;
   logic [2:0] o_sel;
   logic [3:0] o_grant;
   logic [3:0] o_core_busy;
`ifdef ARB_PERF_CNT_EN
   logic [127:0] o_grant_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   m_hart_mem_arbiter #(.N_HARTS(N), .QUANTUM(Q)) dut (
      .CLK         (CLK),
      .RST_X       (RST_X),
      .i_req       (req),
      .i_done      (done),
      .i_lock      (lock),
      .i_mem_busy  (busy),
      .o_valid     (o_valid),
      .o_sel       (o_sel),
      .o_grant     (o_grant),
      .o_core_busy (o_core_busy)
`ifdef ARB_PERF_CNT_EN
      ,
      .o_grant_cnt (o_grant_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Model: who owns the port, whether we are in the dead cycle, last owner,
   // rr pointer, and how many commits the owner made while contested.
   typedef struct {
      int owner;
      bit dead;
      int last;
      int ptr;
      int held;
   } mst_t;

   mst_t m;

   function automatic mst_t reset_state();
      mst_t s;
      s.owner = -1;
      s.dead  = 1'b0;
      s.last  = 0;
      s.ptr   = N - 1;
      s.held  = 0;
      return s;
   endfunction

   function automatic int pick(input logic [3:0] r, input int base);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (base + k) % N;
         if (r[2'(idx)]) return idx;
      end
      return -1;
   endfunction

   function automatic mst_t step(input mst_t s, input logic [3:0] rq, input logic [3:0] dn,
                                 input logic [3:0] lk, input logic bz);
      mst_t       n;
      int         w;
      logic       contested;
      logic [1:0] oi;
      n = s;
      if (s.owner >= 0) begin
         oi        = 2'(s.owner);
         contested = (rq & ~(4'b0001 << oi)) != 4'b0000;
         if (dn[oi] && !lk[oi] && !bz) begin
            if (!rq[oi] || (contested && (s.held + 1 == Q))) begin
               n.last  = s.owner;
               n.owner = -1;
               n.dead  = 1'b1;
               n.held  = 0;
            end else begin
               n.held = contested ? s.held + 1 : 0;
            end
         end
      end else begin
         w      = pick(rq, s.dead ? s.last : s.ptr);
         n.dead = 1'b0;
         if (w >= 0) begin
            n.owner = w;
            n.last  = w;
            n.ptr   = w;
            n.held  = 0;
         end
      end
      return n;
   endfunction

   function automatic logic [3:0] exp_busy(input mst_t s, input logic bz);
      logic [3:0] e;
      for (int g = 0; g < N; g++) e[g] = (s.owner == g) ? bz : 1'b1;
      return e;
   endfunction

   function automatic logic [3:0] exp_grant(input mst_t s);
      return (s.owner >= 0) ? (4'b0001 << 2'(s.owner)) : 4'b0000;
   endfunction

   always @(posedge CLK or negedge RST_X) begin
      if (!RST_X) m <= reset_state();
      else        m <= step(m, req, done, lock, busy);
   end

   // Every-cycle comparison against the model
   always @(negedge CLK) begin
      chk("valid", 32'(o_valid), 32'(m.owner >= 0));
      chk("sel", 32'(o_sel), 32'(m.last));
      chk("grant", 32'(o_grant), 32'(exp_grant(m)));
      chk("core_busy", 32'(o_core_busy), 32'(exp_busy(m, busy)));
   end

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset();
      RST_X = 1'b0;
      req   = 4'b0000;
      done  = 4'b0000;
      lock  = 4'b0000;
      busy  = 1'b0;
      cyc();
      cyc();
   endtask

   initial begin
      int r;
      RST_X = 1'b0;
      req   = 4'b0000;
      done  = 4'b0000;
      lock  = 4'b0000;
      busy  = 1'b0;
      #1;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_grant", 32'(o_grant), 32'd0);
      chk("rst_sel", 32'(o_sel), 32'd0);
      chk("rst_core_busy", 32'(o_core_busy), 32'hF);

      // T2: all request, done every cycle -> 4 cycles per owner then 1 dead cycle
      do_reset();
      req   = 4'hF;
      done  = 4'hF;
      RST_X = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         chk("t2_valid", 32'(o_valid), 32'(((k - 1) % 5) != 4));
         chk("t2_sel", 32'(o_sel), 32'(((k - 1) / 5) % 4));
         if (k <= 21) chk("t2_model_sel", 32'(m.last), 32'(((k - 1) / 5) % 4));
      end
`ifdef ARB_PERF_CNT_EN
      for (int g = 0; g < N; g++) chk("t6_cnt", o_grant_cnt[g*32 +: 32], 32'd2);
`endif

      // T1: reset asserted mid-GRANT between edges
      do_reset();
      req   = 4'hF;
      RST_X = 1'b1;
      cyc();
      cyc();
      chk("t1_pre_valid", 32'(o_valid), 32'd1);
      RST_X = 1'b0;
      #1;
      chk("t1_valid", 32'(o_valid), 32'd0);
      chk("t1_grant", 32'(o_grant), 32'd0);
      chk("t1_core_busy", 32'(o_core_busy), 32'hF);
`ifdef ARB_PERF_CNT_EN
      for (int g = 0; g < N; g++) chk("t6_cnt_rst", o_grant_cnt[g*32 +: 32], 32'd0);
`endif
      cyc();
      req   = 4'b0100;
      RST_X = 1'b1;
      cyc();
      chk("t1_grant_after", 32'(o_grant), 32'h4);
      chk("t1_sel_after", 32'(o_sel), 32'd2);

      // T3: owner 1 locked through 10 commits, then forced out after QUANTUM commits
      do_reset();
      req   = 4'b0010;
      RST_X = 1'b1;
      cyc();
      chk("t3_own1", 32'(o_sel), 32'd1);
      req  = 4'b0011;
      done = 4'b0010;
      lock = 4'b0010;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("t3_locked_sel", 32'(o_sel), 32'd1);
         chk("t3_locked_valid", 32'(o_valid), 32'd1);
      end
      lock = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t3_q_sel", 32'(o_sel), 32'd1);
         chk("t3_q_valid", 32'(o_valid), 32'd1);
      end
      cyc();
      chk("t3_turn_valid", 32'(o_valid), 32'd0);
      chk("t3_turn_sel", 32'(o_sel), 32'd1);
      cyc();
      chk("t3_new_grant", 32'(o_grant), 32'h1);

      // T4: owner 2 and memory busy
      do_reset();
      req   = 4'b0100;
      RST_X = 1'b1;
      cyc();
      req  = 4'hF;
      done = 4'b0100;
      busy = 1'b1;
      #1;
      chk("t4_busy_all", 32'(o_core_busy), 32'hF);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("t4_sel", 32'(o_sel), 32'd2);
         chk("t4_grant", 32'(o_grant), 32'h4);
      end
      busy = 1'b0;
      done = 4'b0000;
      #1;
      chk("t4_busy_owner", 32'(o_core_busy), 32'hB);

      // T5: sole requester never turns; drop request at a commit -> TURN then IDLE
      do_reset();
      req   = 4'b1000;
      RST_X = 1'b1;
      cyc();
      done = 4'b1000;
      for (int k = 0; k < 20; k++) begin
         cyc();
         chk("t5_valid", 32'(o_valid), 32'd1);
         chk("t5_sel", 32'(o_sel), 32'd3);
      end
      req = 4'b0000;
      cyc();
      chk("t5_turn_valid", 32'(o_valid), 32'd0);
      chk("t5_turn_sel", 32'(o_sel), 32'd3);
      chk("t5_model_turn", 32'(m.dead), 32'd1);
      cyc();
      chk("t5_idle_valid", 32'(o_valid), 32'd0);
      chk("t5_idle_grant", 32'(o_grant), 32'd0);

      // Randomized traffic, first half heavily contested
      do_reset();
      RST_X = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         cyc();
         r = int'($urandom % 16);
         if (k < 1500) req = (r < 4) ? 4'($urandom) : 4'hF;
         else if (r == 0) req = 4'($urandom);
         else if (r < 4) req = req ^ (4'b0001 << 2'($urandom % 4));
         done = 4'($urandom);
         lock = 4'($urandom) & 4'($urandom) & 4'($urandom);
         busy = ($urandom % 4) == 0;
         if (($urandom % 700) == 0) begin
            RST_X = 1'b0;
            #1;
            RST_X = 1'b1;
         end
      end
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
